// File: rtl/seq_mult16_pkg.sv
// Shared constants for the MUL execute-stage multiplier: state encodings and default width.
// The control unit decodes busy/done against the same encodings.
package seq_mult16_pkg;

    localparam int MUL_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/seq_mult16.sv
// Multi-cycle shift-add multiplier for the MUL instruction.
// Signed operands are reduced to magnitudes on capture and the sign is restored in FIX.
module seq_mult16
    import seq_mult16_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] OP_ONE    = WIDTH'(1);
    localparam logic [PW-1:0]    ACC_ONE   = PW'(1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic             r_neg;
    logic [PW-1:0]    r_product;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg;

    // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE); while busy=1
    // start is ignored. done is high for exactly the one cycle after product is written.
    assign w_a_mag = (op_signed && a[WIDTH-1]) ? (~a + OP_ONE) : a;
    assign w_b_mag = (op_signed && b[WIDTH-1]) ? (~b + OP_ONE) : b;
    assign w_neg   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Fixed WIDTH iterations even for zero operands, so latency never varies.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_ONE;
                    if (r_count == LAST_ITER) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_product <= r_neg ? (~r_acc + ACC_ONE) : r_acc;
                    r_state   <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign done      = (r_state == ST_DONE);
    assign product   = r_product;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed corners, randomized operands against an
// arithmetic reference model, back-to-back issue, ignored start and asynchronous abort.
module tb_seq_mult16;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op_signed = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    seq_mult16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_signed (op_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: plain integer multiplication of the operands as the mode interprets them.
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
        longint px;
        longint py;
        longint p;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        p = px * py;
        return p[31:0];
    endfunction

    // Caller is positioned just after a rising edge; start is sampled on the next edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is);
        a = ia;
        b = ib;
        op_signed = is;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; gives up after 40 edges.
    task automatic wait_done(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%0b done=%0b exp busy=0 done=0", busy, done);
        end
        checks++;
        if (product !== 32'h0) begin
            failures++;
            $display("FAIL reset_product got=%h exp=00000000", product);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_idle busy=%0b done=%0b product=%h exp 0/0/0", busy, done, product);
        end
    endtask

    task automatic test_basic();
        int busy_cnt;
        int n;
        bit ok;
        busy_cnt = 0;
        n = 0;
        ok = 1'b0;
        issue(16'd3, 16'd5, 1'b0);
        if (busy === 1'b1) busy_cnt++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (!ok || n != W + 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d ok=%0b exp=%0d", n, ok, W + 1);
        end
        checks++;
        if (busy_cnt != W + 1) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cnt, W + 1);
        end
        checks++;
        if (product !== 32'h0000000F || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_product got=%h busy=%0b exp=0000000f busy=0", product, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || product !== 32'h0000000F) begin
            failures++;
            $display("FAIL basic_done_pulse done=%0b product=%h exp done=0 product=0000000f", done, product);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta[7] = '{16'hFFFF, 16'hFFFE, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
        logic [15:0] tb[7] = '{16'hFFFF, 16'h0003, 16'h8000, 16'h1234, 16'h8000, 16'hFFFF, 16'h8000};
        logic        ts[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] te[7] = '{32'hFFFE0001, 32'hFFFFFFFA, 32'h40000000, 32'h00000000,
                               32'h40000000, 32'h00000001, 32'hC0008000};
        int n;
        bit ok;
        for (int i = 0; i < 7; i++) begin
            issue(ta[i], tb[i], ts[i]);
            wait_done(n, ok);
            checks++;
            if (!ok || n != W + 1 || product !== te[i]) begin
                failures++;
                $display("FAIL directed_%0d a=%h b=%h s=%0b got=%h lat=%0d exp=%h lat=%0d",
                         i, ta[i], tb[i], ts[i], product, n, te[i], W + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] corners[4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0001};
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic [31:0] exp_v;
        int n;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 3)];
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs);
            exp_q.push_back(ref_mul(ra, rb, rs));
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            op_signed = ~rs;
            wait_done(n, ok);
            exp_v = exp_q.pop_front();
            checks++;
            if (!ok || n != W + 1 || product !== exp_v) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h s=%0b got=%h lat=%0d exp=%h lat=%0d",
                         i, ra, rb, rs, product, n, exp_v, W + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        a = 16'd7;
        b = 16'd6;
        op_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'd9;
        b = 16'd11;
        wait_done(n, ok);
        checks++;
        if (!ok || n != W + 1 || product !== 32'h0000002A) begin
            failures++;
            $display("FAIL b2b_first got=%h lat=%0d exp=0000002a lat=%0d", product, n, W + 1);
        end
        wait_done(n, ok);
        start = 1'b0;
        checks++;
        if (!ok || n != W + 2 || product !== 32'h00000063) begin
            failures++;
            $display("FAIL b2b_second got=%h spacing=%0d exp=00000063 spacing=%0d", product, n, W + 2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release done=%0b busy=%0b exp 0/0", done, busy);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        int extra;
        bit ok;
        n = 0;
        ok = 1'b0;
        extra = 0;
        issue(16'd11, 16'd13, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                a = 16'd100;
                b = 16'hFF9C;
                op_signed = 1'b1;
                start = 1'b1;
            end
            if (i == 5) start = 1'b0;
            if (done === 1'b1) begin
                n = i;
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!ok || n != W + 1 || product !== 32'd143) begin
            failures++;
            $display("FAIL ignore_start got=%h lat=%0d exp=0000008f lat=%0d", product, n, W + 1);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_no_restart active_cycles=%0d exp=0", extra);
        end
    endtask

    task automatic test_async_reset();
        int n;
        int spurious;
        bit ok;
        logic [31:0] exp_v;
        spurious = 0;
        issue(16'h1234, 16'h5678, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
            failures++;
            $display("FAIL async_reset busy=%0b done=%0b product=%h exp 0/0/00000000", busy, done, product);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1 || product !== 32'h0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL abort_quiet bad_cycles=%0d exp=0", spurious);
        end
        issue(16'hABCD, 16'h8001, 1'b1);
        exp_v = ref_mul(16'hABCD, 16'h8001, 1'b1);
        wait_done(n, ok);
        checks++;
        if (!ok || n != W + 1 || product !== exp_v) begin
            failures++;
            $display("FAIL after_reset got=%h lat=%0d exp=%h lat=%0d", product, n, exp_v, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
